// File: rtl/data_ram.sv
// Byte-addressable data RAM with sub-word access, selectable endianness and a
// fixed, parameterised access latency. Misaligned requests complete with a fault.
module data_ram #(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_CYCLES = 0,
  parameter bit BIG_ENDIAN  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            data_size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_input,
  output logic [31:0]           data_output,
  output logic                  mem_done,
  output logic                  busy,
  output logic                  fault
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  // WAIT holds for WAIT_CYCLES cycles, so the counter is loaded one short.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state, state_next;
  logic [3:0]            count, count_next;
  logic                  we_q, sign_ext_q, fault_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic                  cur_we, cur_sext, misaligned, entering_done;
  logic [1:0]            cur_size, off, off_lo, off_hi;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           cur_wdata, rd_ext;
  logic [3:0]            lane_we;
  logic [3:0][7:0]       lane_wd, rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;

  logic [3:0][7:0]       mem [DEPTH];

  // With no wait states the access completes on the accepting edge, so the
  // live inputs are used while IDLE and the latched copy afterwards.
  assign cur_we    = (state == IDLE) ? we         : we_q;
  assign cur_size  = (state == IDLE) ? data_size  : size_q;
  assign cur_sext  = (state == IDLE) ? sign_ext   : sign_ext_q;
  assign cur_addr  = (state == IDLE) ? address    : addr_q;
  assign cur_wdata = (state == IDLE) ? data_input : wdata_q;

  assign off    = cur_addr[1:0];
  assign off_lo = {off[1], 1'b0};
  assign off_hi = {off[1], 1'b1};

  assign misaligned = (cur_size == 2'b01) ||
                      ((cur_size == 2'b10) && off[0]) ||
                      ((cur_size == 2'b11) && (off != 2'b00));

  assign entering_done = (state_next == DONE) && (state != DONE);

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (req) begin
          if (misaligned || (WAIT_CYCLES == 0)) begin
            state_next = DONE;
          end else begin
            state_next = WAIT;
            count_next = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (count == 4'd0) state_next = DONE;
        else               count_next = count - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sign_ext_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      fault_q     <= 1'b0;
      data_output <= 32'h0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (state == IDLE && req) begin
        we_q       <= we;
        size_q     <= data_size;
        sign_ext_q <= sign_ext;
        addr_q     <= address;
        wdata_q    <= data_input;
      end
      if (entering_done) begin
        fault_q <= misaligned;
        if (!misaligned && !cur_we) data_output <= rd_ext;
      end
    end
  end

  // Memory lane k always holds the byte at word base + k; endianness only
  // decides which data bits travel to which lane.
  always_comb begin
    lane_we = 4'b0000;
    lane_wd = '0;
    case (cur_size)
      2'b00: begin
        lane_we[off] = 1'b1;
        lane_wd[off] = cur_wdata[7:0];
      end
      2'b10: begin
        lane_we[off_lo] = 1'b1;
        lane_we[off_hi] = 1'b1;
        lane_wd[off_lo] = BIG_ENDIAN ? cur_wdata[15:8] : cur_wdata[7:0];
        lane_wd[off_hi] = BIG_ENDIAN ? cur_wdata[7:0]  : cur_wdata[15:8];
      end
      2'b11: begin
        lane_we = 4'b1111;
        lane_wd = BIG_ENDIAN ? {cur_wdata[7:0], cur_wdata[15:8], cur_wdata[23:16], cur_wdata[31:24]}
                             : cur_wdata;
      end
      default: lane_we = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && entering_done && !misaligned && cur_we) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we[k]) mem[cur_addr[ADDR_WIDTH-1:2]][k] <= lane_wd[k];
      end
    end
  end

  assign rd_word = mem[cur_addr[ADDR_WIDTH-1:2]];
  assign rd_byte = rd_word[off];
  assign rd_half = BIG_ENDIAN ? {rd_word[off_lo], rd_word[off_hi]}
                              : {rd_word[off_hi], rd_word[off_lo]};

  always_comb begin
    rd_ext = 32'h0;
    case (cur_size)
      2'b00:   rd_ext = cur_sext ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      2'b10:   rd_ext = cur_sext ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      2'b11:   rd_ext = BIG_ENDIAN ? {rd_word[0], rd_word[1], rd_word[2], rd_word[3]} : rd_word;
      default: rd_ext = 32'h0;
    endcase
  end

  assign busy     = (state != IDLE);
  assign mem_done = (state == DONE);
  assign fault    = (state == DONE) && fault_q;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: three instances cover no-wait little-endian,
// three-wait little-endian and no-wait big-endian configurations.
module tb_data_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_v [3];
  logic        we;
  logic [1:0]  size;
  logic        sx;
  logic [13:0] addr;
  logic [31:0] din;
  logic [31:0] dout_v [3];
  logic        done_v [3];
  logic        busy_v [3];
  logic        fault_v [3];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  data_ram #(.ADDR_WIDTH(14), .WAIT_CYCLES(0), .BIG_ENDIAN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .we(we), .data_size(size), .sign_ext(sx),
    .address(addr), .data_input(din), .data_output(dout_v[0]), .mem_done(done_v[0]),
    .busy(busy_v[0]), .fault(fault_v[0]));

  data_ram #(.ADDR_WIDTH(14), .WAIT_CYCLES(3), .BIG_ENDIAN(1'b0)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .we(we), .data_size(size), .sign_ext(sx),
    .address(addr), .data_input(din), .data_output(dout_v[1]), .mem_done(done_v[1]),
    .busy(busy_v[1]), .fault(fault_v[1]));

  data_ram #(.ADDR_WIDTH(14), .WAIT_CYCLES(0), .BIG_ENDIAN(1'b1)) dutb (
    .clk(clk), .rst_n(rst_n), .req(req_v[2]), .we(we), .data_size(size), .sign_ext(sx),
    .address(addr), .data_input(din), .data_output(dout_v[2]), .mem_done(done_v[2]),
    .busy(busy_v[2]), .fault(fault_v[2]));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request on instance sel and waits (bounded) for its mem_done.
  task automatic applyStimulus(input int sel, input logic w, input logic [1:0] sz, input logic s,
                               input logic [13:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output logic flt, output int lat);
    we = w; size = sz; sx = s; addr = a; din = d;
    req_v[sel] = 1'b1;
    @(posedge clk); #1;
    req_v[sel] = 1'b0;
    lat = 1;
    while (!done_v[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done_v[sel]) checkOutput($sformatf("dut%0d mem_done timeout", sel), 32'd0, 32'd1);
    rd  = dout_v[sel];
    flt = fault_v[sel];
    @(posedge clk); #1;
    checkOutput($sformatf("dut%0d mem_done single cycle", sel), 32'(done_v[sel]), 32'd0);
  endtask

  task automatic access(input string tag, input int sel, input logic w, input logic [1:0] sz,
                        input logic s, input logic [13:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_f);
    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          exp_lat;
    exp_lat = (sel == 1 && !exp_f) ? 4 : 1;
    applyStimulus(sel, w, sz, s, a, d, rd, flt, lat);
    checkOutput($sformatf("%s data", tag), rd, exp_d);
    checkOutput($sformatf("%s fault", tag), 32'(flt), 32'(exp_f));
    checkOutput($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) req_v[i] = 1'b0;
    we = 1'b0; size = 2'b00; sx = 1'b0; addr = 14'h0; din = 32'h0;
    #2 rst_n = 1'b0;
    #10;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset dut%0d busy", i), 32'(busy_v[i]), 32'd0);
      checkOutput($sformatf("reset dut%0d mem_done", i), 32'(done_v[i]), 32'd0);
      checkOutput($sformatf("reset dut%0d fault", i), 32'(fault_v[i]), 32'd0);
      checkOutput($sformatf("reset dut%0d data_output", i), dout_v[i], 32'h0);
    end
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Little-endian, no wait states
    access("le wr word 10",     0, 1'b1, 2'b11, 1'b0, 14'h10, 32'hDEADBEEF, 32'h00000000, 1'b0);
    access("le rd word 10",     0, 1'b0, 2'b11, 1'b0, 14'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    access("le wr byte 11",     0, 1'b1, 2'b00, 1'b0, 14'h11, 32'h0000007F, 32'hDEADBEEF, 1'b0);
    access("le rd word 10 b",   0, 1'b0, 2'b11, 1'b0, 14'h10, 32'h0,        32'hDEAD7FEF, 1'b0);
    access("le rd byte 13 sx",  0, 1'b0, 2'b00, 1'b1, 14'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
    access("le rd byte 13 zx",  0, 1'b0, 2'b00, 1'b0, 14'h13, 32'h0,        32'h000000DE, 1'b0);
    access("le rd half 12 sx",  0, 1'b0, 2'b10, 1'b1, 14'h12, 32'h0,        32'hFFFFDEAD, 1'b0);
    access("le rd half 10 sx",  0, 1'b0, 2'b10, 1'b1, 14'h10, 32'h0,        32'h00007FEF, 1'b0);
    access("le wr word 12 mis", 0, 1'b1, 2'b11, 1'b0, 14'h12, 32'h55555555, 32'h00007FEF, 1'b1);
    access("le rd half 11 mis", 0, 1'b0, 2'b10, 1'b1, 14'h11, 32'h0,        32'h00007FEF, 1'b1);
    access("le rd size01 mis",  0, 1'b0, 2'b01, 1'b0, 14'h10, 32'h0,        32'h00007FEF, 1'b1);
    access("le rd word 10 c",   0, 1'b0, 2'b11, 1'b1, 14'h10, 32'h0,        32'hDEAD7FEF, 1'b0);
    access("le wr half 14",     0, 1'b1, 2'b10, 1'b0, 14'h14, 32'h0000A5C3, 32'hDEAD7FEF, 1'b0);
    access("le rd half 14 sx",  0, 1'b0, 2'b10, 1'b1, 14'h14, 32'h0,        32'hFFFFA5C3, 1'b0);
    access("le rd byte 15 zx",  0, 1'b0, 2'b00, 1'b0, 14'h15, 32'h0,        32'h000000A5, 1'b0);

    // Big-endian
    access("be wr word 20",     2, 1'b1, 2'b11, 1'b0, 14'h20, 32'h11223344, 32'h00000000, 1'b0);
    access("be rd byte 20",     2, 1'b0, 2'b00, 1'b0, 14'h20, 32'h0,        32'h00000011, 1'b0);
    access("be rd half 22",     2, 1'b0, 2'b10, 1'b0, 14'h22, 32'h0,        32'h00003344, 1'b0);
    access("be rd word 20",     2, 1'b0, 2'b11, 1'b0, 14'h20, 32'h0,        32'h11223344, 1'b0);
    access("be rd byte 23",     2, 1'b0, 2'b00, 1'b1, 14'h23, 32'h0,        32'h00000044, 1'b0);
    access("be wr half 24",     2, 1'b1, 2'b10, 1'b0, 14'h24, 32'h0000ABCD, 32'h00000044, 1'b0);
    access("be rd byte 24",     2, 1'b0, 2'b00, 1'b0, 14'h24, 32'h0,        32'h000000AB, 1'b0);
    access("be rd half 24 sx",  2, 1'b0, 2'b10, 1'b1, 14'h24, 32'h0,        32'hFFFFABCD, 1'b0);

    // Three wait states
    access("w3 wr word 30",     1, 1'b1, 2'b11, 1'b0, 14'h30, 32'h01020304, 32'h00000000, 1'b0);
    access("w3 rd half 31 mis", 1, 1'b0, 2'b10, 1'b0, 14'h31, 32'h0,        32'h00000000, 1'b1);

    we = 1'b0; size = 2'b11; sx = 1'b0; addr = 14'h30; din = 32'h0;
    req_v[1] = 1'b1;
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      checkOutput($sformatf("w3 busy cycle N+%0d", k), 32'(busy_v[1]), 32'(k <= 4));
      checkOutput($sformatf("w3 mem_done cycle N+%0d", k), 32'(done_v[1]), 32'(k == 4));
      if (k == 4) begin
        checkOutput("w3 timed read data", dout_v[1], 32'h01020304);
        checkOutput("w3 timed read fault", 32'(fault_v[1]), 32'd0);
      end
      if (k == 2) req_v[1] = 1'b1;
      if (k == 3) req_v[1] = 1'b0;
      @(posedge clk); #1;
    end

    // Reset during a pending write
    we = 1'b1; size = 2'b11; addr = 14'h30; din = 32'hCAFEF00D;
    req_v[1] = 1'b1;
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(busy_v[1]), 32'd0);
    checkOutput("midreset mem_done", 32'(done_v[1]), 32'd0);
    checkOutput("midreset fault", 32'(fault_v[1]), 32'd0);
    checkOutput("midreset data_output", dout_v[1], 32'h0);
    checkOutput("midreset dut0 data_output", dout_v[0], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    access("w3 rd word 30 after reset", 1, 1'b0, 2'b11, 1'b0, 14'h30, 32'h0, 32'h01020304, 1'b0);
    access("le rd word 10 after reset", 0, 1'b0, 2'b11, 1'b0, 14'h10, 32'h0, 32'hDEAD7FEF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
